banked_vector_regfile: RTL and testbench

//  Per-warp vector register file split into NUM_BANKS single-read-port banks, with a two-operand

---
 rtl/banked_vector_regfile.sv | 195 +++++++++++++++++++
 tb/tb_banked_vector_regfile.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/banked_vector_regfile.sv
// Per-warp vector register file: NUM_BANKS single-read-port banks, two-operand read handshake with
// conflict serialisation, masked writeback with bypass, and a busy-bit scoreboard. Optional
// performance counters are built when RF_PERF_COUNTERS_EN is defined.
module banked_vector_regfile #(
  parameter int NUM_WARPS = 32,
  parameter int NUM_REGS  = 32,
  parameter int THREADS   = 32,
  parameter int DATA_W    = 32,
  parameter int NUM_BANKS = 4,
  localparam int WARP_W   = $clog2(NUM_WARPS),
  localparam int REG_W    = $clog2(NUM_REGS),
  localparam int LANE_W   = THREADS * DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef RF_PERF_COUNTERS_EN
  output logic [31:0]       perf_reads,
  output logic [31:0]       perf_writes,
  output logic [31:0]       perf_conflicts,
`endif
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [WARP_W-1:0] rd_req_warp,
  input  logic [REG_W-1:0]  rd_req_rs1,
  input  logic [REG_W-1:0]  rd_req_rs2,
  output logic              rd_hazard,
  output logic              rsp_valid,
  output logic [WARP_W-1:0] rsp_warp,
  output logic [LANE_W-1:0] rs1_data,
  output logic [LANE_W-1:0] rs2_data,
  input  logic              wr_en,
  input  logic [WARP_W-1:0] wr_warp,
  input  logic [REG_W-1:0]  wr_reg,
  input  logic [THREADS-1:0] wr_mask,
  input  logic [LANE_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [WARP_W-1:0] rsv_warp,
  input  logic [REG_W-1:0]  rsv_reg
);
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int IDX_W  = WARP_W + REG_W - BANK_W;
  localparam int DEPTH  = NUM_WARPS * NUM_REGS / NUM_BANKS;

  typedef enum logic {IDLE, SECOND} state_t;
  state_t state, state_nx;

  logic [NUM_WARPS-1:0][NUM_REGS-1:0] busy;
  logic [WARP_W-1:0] lat_warp;
  logic [REG_W-1:0]  lat_rs2;
  logic [LANE_W-1:0] hold;

  function automatic logic [BANK_W-1:0] bank_of(input logic [WARP_W-1:0] w, input logic [REG_W-1:0] r);
    logic [BANK_W-1:0] rb, wb;
    rb = r[BANK_W-1:0];
    wb = w[BANK_W-1:0];
    return rb + wb;
  endfunction

  // Within a bank, the warp plus the upper register bits identify the entry uniquely.
  function automatic logic [IDX_W-1:0] idx_of(input logic [WARP_W-1:0] w, input logic [REG_W-1:0] r);
    return {w, r[REG_W-1:BANK_W]};
  endfunction

  // Active read phase: the request in IDLE, the latched rs2 alone in SECOND.
  logic [WARP_W-1:0] p_warp;
  logic [REG_W-1:0]  p_r1, p_r2;
  always_comb begin
    p_warp = rd_req_warp;
    p_r1   = rd_req_rs1;
    p_r2   = rd_req_rs2;
    if (state == SECOND) begin
      p_warp = lat_warp;
      p_r1   = lat_rs2;
      p_r2   = '0;
    end
  end

  logic [BANK_W-1:0] b1, b2, wbank;
  logic [IDX_W-1:0]  idx1, idx2, widx;
  assign b1    = bank_of(p_warp, p_r1);
  assign b2    = bank_of(p_warp, p_r2);
  assign idx1  = idx_of(p_warp, p_r1);
  assign idx2  = idx_of(p_warp, p_r2);
  assign wbank = bank_of(wr_warp, wr_reg);
  assign widx  = idx_of(wr_warp, wr_reg);

  logic wr_live;
  assign wr_live = wr_en && (wr_reg != '0);

  logic [NUM_BANKS-1:0][IDX_W-1:0]  bank_raddr;
  logic [NUM_BANKS-1:0][LANE_W-1:0] bank_rdata;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [LANE_W-1:0] mem [DEPTH];
    assign bank_raddr[b] = (BANK_W'(b) == b1 && p_r1 != '0) ? idx1 : idx2;
    assign bank_rdata[b] = mem[bank_raddr[b]];
    always_ff @(posedge clk) begin
      if (wr_live && wbank == BANK_W'(b))
        for (int t = 0; t < THREADS; t++)
          if (wr_mask[t]) mem[widx][t*DATA_W +: DATA_W] <= wr_data[t*DATA_W +: DATA_W];
    end
  end

  logic hit1, hit2;
  logic [LANE_W-1:0] v1, v2;
  assign hit1 = wr_live && wr_warp == p_warp && wr_reg == p_r1;
  assign hit2 = wr_live && wr_warp == p_warp && wr_reg == p_r2;

  // Masked lanes of a same-cycle write are forwarded over the stored value.
  always_comb begin
    v1 = '0;
    v2 = '0;
    if (p_r1 != '0) v1 = bank_rdata[b1];
    if (p_r2 != '0) v2 = bank_rdata[b2];
    for (int t = 0; t < THREADS; t++) begin
      if (hit1 && wr_mask[t]) v1[t*DATA_W +: DATA_W] = wr_data[t*DATA_W +: DATA_W];
      if (hit2 && wr_mask[t]) v2[t*DATA_W +: DATA_W] = wr_data[t*DATA_W +: DATA_W];
    end
  end

  logic conflict, accept;
  assign rd_hazard = busy[rd_req_warp][rd_req_rs1] || busy[rd_req_warp][rd_req_rs2];
  assign rd_req_ready = rst_n && (state == IDLE) && !rd_hazard;
  assign accept = rd_req_valid && rd_req_ready;
  assign conflict = (rd_req_rs1 != '0) && (rd_req_rs2 != '0) && (rd_req_rs1 != rd_req_rs2) &&
                    (bank_of(rd_req_warp, rd_req_rs1) == bank_of(rd_req_warp, rd_req_rs2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && conflict) state_nx = SECOND;
      SECOND:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_warp  <= '0;
      rs1_data  <= '0;
      rs2_data  <= '0;
      hold      <= '0;
      lat_warp  <= '0;
      lat_rs2   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (state == SECOND) begin
        rsp_valid <= 1'b1;
        rsp_warp  <= lat_warp;
        rs1_data  <= hold;
        rs2_data  <= v1;
      end else if (accept) begin
        if (conflict) begin
          hold     <= v1;
          lat_warp <= rd_req_warp;
          lat_rs2  <= rd_req_rs2;
        end else begin
          rsp_valid <= 1'b1;
          rsp_warp  <= rd_req_warp;
          rs1_data  <= v1;
          rs2_data  <= v2;
        end
      end
    end
  end

  // Clear before set so a same-cycle reserve of the same entry wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else begin
      if (wr_live) busy[wr_warp][wr_reg] <= 1'b0;
      if (rsv_en && rsv_reg != '0) busy[rsv_warp][rsv_reg] <= 1'b1;
    end
  end

`ifdef RF_PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_reads     <= '0;
      perf_writes    <= '0;
      perf_conflicts <= '0;
    end else begin
      if (accept)             perf_reads     <= perf_reads + 32'd1;
      if (wr_live)            perf_writes    <= perf_writes + 32'd1;
      if (accept && conflict) perf_conflicts <= perf_conflicts + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_banked_vector_regfile.sv
// Directed bench for banked_vector_regfile: table of read requests over preloaded registers, plus
// sequences for bypass, scoreboard hazards, reset during a serialised read and perf counters.
module tb_banked_vector_regfile;
  localparam int LANE = 1024;

  logic clk = 1'b0, rst_n = 1'b0;
  logic rd_req_valid = 1'b0, rd_req_ready, rd_hazard, rsp_valid;
  logic [4:0] rd_req_warp = '0, rd_req_rs1 = '0, rd_req_rs2 = '0, rsp_warp;
  logic [LANE-1:0] rs1_data, rs2_data, wr_data = '0;
  logic wr_en = 1'b0, rsv_en = 1'b0;
  logic [4:0] wr_warp = '0, wr_reg = '0, rsv_warp = '0, rsv_reg = '0;
  logic [31:0] wr_mask = '0;
`ifdef RF_PERF_COUNTERS_EN
  logic [31:0] perf_reads, perf_writes, perf_conflicts;
`endif

  banked_vector_regfile dut (
    .clk(clk), .rst_n(rst_n),
`ifdef RF_PERF_COUNTERS_EN
    .perf_reads(perf_reads), .perf_writes(perf_writes), .perf_conflicts(perf_conflicts),
`endif
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_warp(rd_req_warp),
    .rd_req_rs1(rd_req_rs1), .rd_req_rs2(rd_req_rs2), .rd_hazard(rd_hazard),
    .rsp_valid(rsp_valid), .rsp_warp(rsp_warp), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wr_en(wr_en), .wr_warp(wr_warp), .wr_reg(wr_reg), .wr_mask(wr_mask), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_warp(rsv_warp), .rsv_reg(rsv_reg)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [LANE-1:0] got, input logic [LANE-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [LANE-1:0] pat(input int w, input int r);
    logic [LANE-1:0] v;
    for (int t = 0; t < 32; t++) v[t*32 +: 32] = {8'(w), 8'(r), 16'(t)};
    return v;
  endfunction

  function automatic logic [LANE-1:0] fill(input logic [31:0] x);
    logic [LANE-1:0] v;
    for (int t = 0; t < 32; t++) v[t*32 +: 32] = x;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_write(input int w, input int r, input logic [31:0] m, input logic [LANE-1:0] d);
    wr_en = 1'b1; wr_warp = 5'(w); wr_reg = 5'(r); wr_mask = m; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Returns ready at request time, ready after the accepting edge, latency (0 = timed out) and data.
  task automatic do_read(input int w, input int r1, input int r2, output logic rdy0, output logic rdy1,
                         output int lat, output logic [LANE-1:0] d1, output logic [LANE-1:0] d2,
                         output logic [4:0] rw);
    rd_req_valid = 1'b1; rd_req_warp = 5'(w); rd_req_rs1 = 5'(r1); rd_req_rs2 = 5'(r2);
    #1 rdy0 = rd_req_ready;
    @(posedge clk); #1;
    rd_req_valid = 1'b0;
    rdy1 = rd_req_ready;
    lat = 0; d1 = '0; d2 = '0; rw = '0;
    for (int i = 1; i <= 4; i++) begin
      if (rsp_valid) begin
        lat = i; d1 = rs1_data; d2 = rs2_data; rw = rsp_warp;
        break;
      end
      tick();
    end
    tick();
  endtask

  typedef struct { int w; int r1; int r2; int lat; } vec_t;
  vec_t tbl[9];

  logic rdy0, rdy1;
  int lat;
  logic [LANE-1:0] d1, d2, exp1, exp2, e;
  logic [4:0] rw;
  int seen;

  initial begin
    tbl[0] = '{0, 1, 2, 1};
    tbl[1] = '{0, 1, 5, 2};
    tbl[2] = '{0, 5, 1, 2};
    tbl[3] = '{0, 1, 1, 1};
    tbl[4] = '{0, 0, 5, 1};
    tbl[5] = '{0, 5, 0, 1};
    tbl[6] = '{5, 4, 8, 2};
    tbl[7] = '{5, 4, 0, 1};
    tbl[8] = '{0, 2, 5, 1};

    #12;
    chk("reset_ready", rd_req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_warp", rsp_warp, 0);
    chk("reset_rs1_data", rs1_data, 0);
    chk("reset_rs2_data", rs2_data, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    #1 chk("ready_after_reset", rd_req_ready, 1);

    do_write(0, 1, 32'hFFFF_FFFF, pat(0, 1));
    do_write(0, 2, 32'hFFFF_FFFF, pat(0, 2));
    do_write(0, 5, 32'hFFFF_FFFF, pat(0, 5));
    do_write(5, 4, 32'hFFFF_FFFF, pat(5, 4));
    do_write(5, 8, 32'hFFFF_FFFF, pat(5, 8));
    do_write(2, 7, 32'hFFFF_FFFF, fill(32'h22));
    do_write(0, 0, 32'hFFFF_FFFF, fill(32'hDEAD));

    // Test 1
    for (int t = 0; t < 32; t++) e[t*32 +: 32] = 32'hA5A5_0000 + t;
    do_write(3, 5, 32'hFFFF_FFFF, e);
    do_read(3, 5, 0, rdy0, rdy1, lat, d1, d2, rw);
    chk("t1_lat", lat, 1);
    chk("t1_ready_hold", rdy1, 1);
    chk("t1_rs1", d1, e);
    chk("t1_rs2", d2, 0);
    chk("t1_warp", rw, 3);

    // Table: latency, ready behaviour and operand data
    for (int i = 0; i < 9; i++) begin
      exp1 = (tbl[i].r1 == 0) ? '0 : pat(tbl[i].w, tbl[i].r1);
      exp2 = (tbl[i].r2 == 0) ? '0 : pat(tbl[i].w, tbl[i].r2);
      do_read(tbl[i].w, tbl[i].r1, tbl[i].r2, rdy0, rdy1, lat, d1, d2, rw);
      chk($sformatf("v%0d_ready", i), rdy0, 1);
      chk($sformatf("v%0d_ready_after", i), rdy1, (tbl[i].lat == 1) ? 1 : 0);
      chk($sformatf("v%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("v%0d_rs1", i), d1, exp1);
      chk($sformatf("v%0d_rs2", i), d2, exp2);
      chk($sformatf("v%0d_warp", i), rw, tbl[i].w);
    end

    // Test 3: same-cycle masked write bypass
    for (int t = 0; t < 32; t++) e[t*32 +: 32] = (t < 16) ? 32'h11 : 32'h22;
    rd_req_valid = 1'b1; rd_req_warp = 5'd2; rd_req_rs1 = 5'd7; rd_req_rs2 = 5'd0;
    wr_en = 1'b1; wr_warp = 5'd2; wr_reg = 5'd7; wr_mask = 32'h0000_FFFF; wr_data = fill(32'h11);
    tick();
    rd_req_valid = 1'b0; wr_en = 1'b0;
    chk("t3_bypass_valid", rsp_valid, 1);
    chk("t3_bypass_data", rs1_data, e);
    tick();
    do_read(2, 7, 0, rdy0, rdy1, lat, d1, d2, rw);
    chk("t3_stored_data", d1, e);

    // Bypass into the SECOND phase of a conflicting read
    rd_req_valid = 1'b1; rd_req_warp = 5'd5; rd_req_rs1 = 5'd4; rd_req_rs2 = 5'd8;
    tick();
    rd_req_valid = 1'b0;
    chk("second_no_rsp", rsp_valid, 0);
    wr_en = 1'b1; wr_warp = 5'd5; wr_reg = 5'd8; wr_mask = 32'hFFFF_FFFF; wr_data = fill(32'h77);
    tick();
    wr_en = 1'b0;
    chk("second_rsp", rsp_valid, 1);
    chk("second_rs1", rs1_data, pat(5, 4));
    chk("second_rs2_bypass", rs2_data, fill(32'h77));
    tick();

    // Test 4: scoreboard
    rsv_en = 1'b1; rsv_warp = 5'd1; rsv_reg = 5'd9;
    rd_req_warp = 5'd1; rd_req_rs1 = 5'd9; rd_req_rs2 = 5'd0;
    #1 chk("t4_hazard_before_edge", rd_hazard, 0);
    tick();
    rsv_en = 1'b0;
    rd_req_valid = 1'b1;
    #1 chk("t4_hazard", rd_hazard, 1);
    chk("t4_ready_low", rd_req_ready, 0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rsp_valid) seen++;
    end
    rd_req_valid = 1'b0;
    chk("t4_no_rsp", seen, 0);
    do_write(1, 9, 32'h0, fill(32'h0));
    chk("t4_hazard_cleared", rd_hazard, 0);
    rsv_en = 1'b1; rsv_warp = 5'd1; rsv_reg = 5'd9;
    wr_en = 1'b1; wr_warp = 5'd1; wr_reg = 5'd9; wr_mask = 32'h0;
    tick();
    rsv_en = 1'b0; wr_en = 1'b0;
    chk("t4_set_wins", rd_hazard, 1);
    rsv_en = 1'b1; rsv_warp = 5'd1; rsv_reg = 5'd0;
    rd_req_rs1 = 5'd0;
    tick();
    rsv_en = 1'b0;
    chk("t4_r0_never_busy", rd_hazard, 0);

    // Test 5: reset during SECOND (w1 r9 still busy)
    rd_req_valid = 1'b1; rd_req_warp = 5'd0; rd_req_rs1 = 5'd1; rd_req_rs2 = 5'd5;
    tick();
    rd_req_valid = 1'b0;
    rst_n = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      #1 if (rsp_valid) seen++;
      tick();
    end
    chk("t5_no_rsp_in_reset", seen, 0);
    chk("t5_ready_in_reset", rd_req_ready, 0);
    rst_n = 1'b1;
    rd_req_warp = 5'd1; rd_req_rs1 = 5'd9; rd_req_rs2 = 5'd0;
    #1 chk("t5_busy_cleared", rd_hazard, 0);
    chk("t5_ready_after", rd_req_ready, 1);
    tick();
    chk("t5_no_late_rsp", rsp_valid, 0);

    // Test 6: storage survives reset; counter traffic
    do_read(0, 1, 2, rdy0, rdy1, lat, d1, d2, rw);
    chk("t6_lat", lat, 1);
    chk("t6_rs1_after_reset", d1, pat(0, 1));
    do_read(0, 1, 5, rdy0, rdy1, lat, d1, d2, rw);
    chk("t6_conflict_lat", lat, 2);
    do_read(0, 2, 0, rdy0, rdy1, lat, d1, d2, rw);
    chk("t6_rs1_r2", d1, pat(0, 2));
    do_write(0, 2, 32'hFFFF_FFFF, pat(0, 2));
    do_write(0, 0, 32'hFFFF_FFFF, fill(32'hBEEF));
`ifdef RF_PERF_COUNTERS_EN
    chk("t6_perf_reads", perf_reads, 3);
    chk("t6_perf_writes", perf_writes, 1);
    chk("t6_perf_conflicts", perf_conflicts, 1);
`endif
    do_read(0, 0, 2, rdy0, rdy1, lat, d1, d2, rw);
    chk("t6_r0_write_ignored", d1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
